// File: rtl/new_task_arbiter_if.sv
// Stream bundle around the new-task arbiter: per-accelerator AXI-Stream inputs (s_*) and the merged output (m_*).
// The arbiter takes the slave modport; the accelerator/manager side takes the master modport.
interface new_task_arbiter_if #(
    parameter int MAX_ACCS = 16
) ();
    localparam int ACC_BITS = $clog2(MAX_ACCS);

    logic [MAX_ACCS-1:0]    s_tvalid;
    logic [MAX_ACCS-1:0]    s_tready;
    logic [64*MAX_ACCS-1:0] s_tdata;
    logic [MAX_ACCS-1:0]    s_tlast;
    logic [5*MAX_ACCS-1:0]  s_tdest;

    logic                   m_tvalid;
    logic                   m_tready;
    logic [63:0]            m_tdata;
    logic                   m_tlast;
    logic [ACC_BITS-1:0]    m_tid;
    logic [4:0]             m_tdest;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, s_tdest, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, s_tdest, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest
    );
endinterface

// File: rtl/new_task_arbiter.sv
// Packet-locked round-robin merge of per-accelerator new-task streams, tagged with the source index on m_tid,
// behind a registered output with a one-entry skid buffer. Define NEW_TASK_ARB_PKT_COUNT_EN to add pkt_count.
module new_task_arbiter #(
    parameter int MAX_ACCS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    new_task_arbiter_if.slave bus
`ifdef NEW_TASK_ARB_PKT_COUNT_EN
    ,
    output logic [31:0]       pkt_count
`endif
);
    localparam int ACC_BITS = $clog2(MAX_ACCS);

    typedef enum logic {IDLE, XFER} state_t;

    typedef struct packed {
        logic [63:0]         data;
        logic                last;
        logic [ACC_BITS-1:0] id;
        logic [4:0]          dest;
    } beat_t;

    state_t              state;
    logic [ACC_BITS-1:0] grant;
    logic [ACC_BITS-1:0] last_grant;
    logic [ACC_BITS-1:0] next_grant;
    logic [ACC_BITS-1:0] cand;
    logic                found;
    logic                any_req;

    logic [63:0]         chan_data [MAX_ACCS];
    logic [4:0]          chan_dest [MAX_ACCS];

    beat_t               in_beat;
    beat_t               main_beat;
    beat_t               skid_beat;
    logic                main_valid;
    logic                skid_valid;
    logic                accept;
    logic                drain;
    logic [MAX_ACCS-1:0] s_tready;

    always_comb begin
        for (int i = 0; i < MAX_ACCS; i++) begin
            chan_data[i] = bus.s_tdata[64*i +: 64];
            chan_dest[i] = bus.s_tdest[5*i +: 5];
        end
    end

    // Round-robin scan starting just after the last packet's owner, wrapping at MAX_ACCS-1.
    always_comb begin
        // NOTE: blocking assignments with defaults up front keep this block purely combinational; a missing default would infer a latch.
        next_grant = last_grant;
        found      = 1'b0;
        cand       = last_grant;
        for (int off = 0; off < MAX_ACCS; off++) begin
            cand = (cand == ACC_BITS'(MAX_ACCS - 1)) ? '0 : cand + ACC_BITS'(1);
            if (!found && bus.s_tvalid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    assign any_req = |bus.s_tvalid;

    always_comb begin
        in_beat = '{data: chan_data[grant], last: bus.s_tlast[grant], id: grant, dest: chan_dest[grant]};
    end

    // A full skid entry back-pressures the granted channel, so the slice never holds more than two beats.
    assign accept = (state == XFER) && bus.s_tvalid[grant] && !skid_valid;
    assign drain  = main_valid && bus.m_tready;

    always_comb begin
        s_tready = '0;
        if (state == XFER && !skid_valid) begin
            s_tready[grant] = 1'b1;
        end
    end

    assign bus.s_tready = s_tready;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ACC_BITS'(MAX_ACCS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept && in_beat.last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    // Output slice: a new beat goes to main whenever main is free or leaving this cycle, otherwise to skid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_beat  <= '0;
            skid_beat  <= '0;
        end else if (accept) begin
            if (!main_valid || bus.m_tready) begin
                main_beat  <= in_beat;
                main_valid <= 1'b1;
            end else begin
                skid_beat  <= in_beat;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            if (skid_valid) begin
                main_beat  <= skid_beat;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.m_tvalid = main_valid;
    assign bus.m_tdata  = main_beat.data;
    assign bus.m_tlast  = main_beat.last;
    assign bus.m_tid    = main_beat.id;
    assign bus.m_tdest  = main_beat.dest;

`ifdef NEW_TASK_ARB_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_count <= '0;
        end else if (drain && main_beat.last) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_new_task_arbiter.sv
// Bench for new_task_arbiter (MAX_ACCS=4): directed scenarios plus random traffic, scored against a packet-level round-robin model.
module tb_new_task_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [4:0]  dest;
    } in_beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  tid;
        logic [4:0]  dest;
    } out_beat_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    new_task_arbiter_if #(.MAX_ACCS(N)) bus ();
`ifdef NEW_TASK_ARB_PKT_COUNT_EN
    logic [31:0] pkt_count;
`endif

    new_task_arbiter #(.MAX_ACCS(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef NEW_TASK_ARB_PKT_COUNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    int        n_checks = 0;
    int        n_fail   = 0;

    in_beat_t  chq [N][$];     // beats each channel still has to offer
    int        pl  [N][$];     // packet lengths, consumed by plan()
    out_beat_t exp_q [$];      // expected merged stream
    int        start_q [$];    // tid of each packet as it appears on the output
    int        bub [N];
    int        force_bub [N];
    bit        rand_bub;
    int        rdy_mode;
    int        rcnt;
    int        mlg;            // model's last granted channel
    int        held;           // beats accepted on input but not yet delivered
    int        acc_total;
    int        pkts_done;
    bit        in_pkt;

    logic [N-1:0] smp_hs;
    logic [N-1:0] smp_tready;
    logic         smp_out_hs;
    logic         smp_rstn;
    out_beat_t    smp_out;
    out_beat_t    prev_out;
    logic         prev_stall;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (chq[i].size() > 0 && bub[i] == 0) begin
                bus.s_tvalid[i]         = 1'b1;
                bus.s_tdata[64*i +: 64] = chq[i][0].data;
                bus.s_tlast[i]          = chq[i][0].last;
                bus.s_tdest[5*i +: 5]   = chq[i][0].dest;
            end else begin
                bus.s_tvalid[i]         = 1'b0;
                bus.s_tdata[64*i +: 64] = '0;
                bus.s_tlast[i]          = 1'b0;
                bus.s_tdest[5*i +: 5]   = '0;
            end
        end
        if (!rstn)               bus.m_tready = 1'b0;
        else if (rdy_mode == 0)  bus.m_tready = 1'b1;
        else if (rdy_mode == 1)  bus.m_tready = (rcnt % 3 == 0);
        else                     bus.m_tready = 1'($urandom_range(0, 1));
        rcnt++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            chq[i].delete();
            pl[i].delete();
            bub[i]       = 0;
            force_bub[i] = 0;
        end
        exp_q.delete();
        held       = 0;
        mlg        = N - 1;
        in_pkt     = 1'b0;
        pkts_done  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [63:0] base, input logic [4:0] dest);
        for (int j = 0; j < len; j++) begin
            chq[ch].push_back('{data: base + 64'(j), last: (j == len - 1), dest: dest});
        end
        pl[ch].push_back(len);
    endtask

    // Packet-level round robin: each whole packet goes to the next channel after the previous owner that still has one queued.
    task automatic plan();
        int idx [N];
        int pick;
        int len;
        bit more;
        for (int i = 0; i < N; i++) idx[i] = 0;
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && pl[(mlg + k) % N].size() > 0) pick = (mlg + k) % N;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                len = pl[pick].pop_front();
                for (int j = 0; j < len; j++) begin
                    exp_q.push_back('{data: chq[pick][idx[pick] + j].data, last: chq[pick][idx[pick] + j].last,
                                      tid: 2'(pick), dest: chq[pick][idx[pick] + j].dest});
                end
                idx[pick] += len;
                mlg = pick;
            end
        end
    endtask

    task automatic cycle();
        in_beat_t  b;
        out_beat_t e;
        @(negedge clk);
        smp_rstn   = rstn;
        smp_tready = bus.s_tready;
        smp_hs     = bus.s_tvalid & bus.s_tready;
        smp_out    = '{data: bus.m_tdata, last: bus.m_tlast, tid: bus.m_tid, dest: bus.m_tdest};
        smp_out_hs = rstn && bus.m_tvalid && bus.m_tready;
        if (held == 2) chk("s_tready low while skid holds a beat", bus.s_tready, '0);
        if (prev_stall) chk("m_* stable while stalled", {bus.m_tvalid, smp_out}, {1'b1, prev_out});
        prev_stall = rstn && bus.m_tvalid && !bus.m_tready;
        prev_out   = smp_out;
        @(posedge clk);
        #1;
        if (!smp_rstn) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (smp_hs[i]) begin
                    b = chq[i].pop_front();
                    held++;
                    acc_total++;
                    if (!b.last) begin
                        if (force_bub[i] > 0) begin
                            bub[i]       = force_bub[i];
                            force_bub[i] = 0;
                        end else if (rand_bub) begin
                            bub[i] = $urandom_range(0, 2);
                        end
                    end
                end else if (bub[i] > 0) begin
                    bub[i]--;
                end
            end
            if (smp_out_hs) begin
                held--;
                chk("output beat was expected", 1'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("output beat", smp_out, e);
                end
                if (!in_pkt) start_q.push_back(int'(smp_out.tid));
                in_pkt = !smp_out.last;
                if (smp_out.last) pkts_done++;
            end
        end
        drive();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("stream drained within budget", exp_q.size(), 0);
        chk("slice empty after drain", held, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive();
        cycle();
        cycle();
        rstn = 1'b1;
        drive();
        cycle();
    endtask

    initial begin
        int exp_order [4];
        int start;
        int n;
        bit done;

        rstn      = 1'b0;
        rand_bub  = 1'b0;
        rdy_mode  = 0;
        rcnt      = 0;
        acc_total = 0;
        model_reset();
        drive();
        do_reset();

        // Single 3-beat packet on channel 2: two-cycle latency, then 1 beat/cycle.
        add_pkt(2, 3, 64'hA0, 5'd3);
        plan();
        drive();
        cycle();
        chk("m_tvalid low after arbitration cycle", bus.m_tvalid, 0);
        cycle();
        chk("m_tvalid high two cycles after request", bus.m_tvalid, 1);
        wait_drain(50);

        // Channels 0, 1, 3 from reset, channel 0 with a second packet: order 0, 1, 3, 0.
        do_reset();
        start_q.delete();
        add_pkt(0, 2, 64'h100, 5'd1);
        add_pkt(1, 2, 64'h200, 5'd2);
        add_pkt(3, 2, 64'h300, 5'd4);
        add_pkt(0, 2, 64'h110, 5'd5);
        plan();
        drive();
        wait_drain(100);
        exp_order = '{0, 1, 3, 0};
        chk("packets seen in round robin test", start_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("grant order slot %0d", k), (k < start_q.size()) ? start_q[k] : -1, exp_order[k]);
        end

        // 5-beat packet on channel 1 with m_tready pattern 1,0,0.
        rdy_mode = 1;
        add_pkt(1, 5, 64'h5000, 5'd17);
        plan();
        drive();
        wait_drain(100);
        rdy_mode = 0;
        chk("packets forwarded since reset", pkts_done, 5);
`ifdef NEW_TASK_ARB_PKT_COUNT_EN
        chk("pkt_count after five packets", pkt_count, 5);
`endif

        // Reset while beat 2 of a 4-beat packet is offered.
        add_pkt(2, 4, 64'hC0, 5'd1);
        plan();
        drive();
        start = acc_total;
        n = 0;
        while (acc_total - start < 1 && n < 20) begin
            cycle();
            n++;
        end
        chk("first beat accepted before reset", acc_total - start, 1);
        rstn = 1'b0;
        drive();
        cycle();
        chk("m_tvalid cleared by reset", bus.m_tvalid, 0);
        chk("s_tready cleared by reset", bus.s_tready, '0);
        rstn = 1'b1;
        drive();
        repeat (3) cycle();
        chk("no partial beat after reset", bus.m_tvalid, 0);

        // Channel 0 (priority after reset) stalls 4 cycles mid-packet while channel 3 waits.
        add_pkt(0, 3, 64'hD0, 5'd7);
        add_pkt(3, 2, 64'hE0, 5'd9);
        force_bub[0] = 4;
        start_q.delete();
        plan();
        drive();
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            cycle();
            n++;
            chk("channel 3 not ready while channel 0 holds grant", smp_tready[3], 0);
            done = (chq[0].size() == 0);
        end
        chk("channel 0 packet completed", done, 1);
        wait_drain(50);
        chk("channel 0 served first after reset", (start_q.size() > 0) ? start_q[0] : -1, 0);

        // Random traffic: random lengths, payloads, mid-packet bubbles and back-pressure.
        rand_bub = 1'b1;
        rdy_mode = 2;
        for (int r = 0; r < 40; r++) begin
            for (int ch = 0; ch < N; ch++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    add_pkt(ch, $urandom_range(1, 5), {$urandom(), $urandom()}, 5'($urandom_range(0, 31)));
                end
            end
            plan();
            drive();
            wait_drain(400);
        end
`ifdef NEW_TASK_ARB_PKT_COUNT_EN
        chk("pkt_count matches forwarded packets", pkt_count, pkts_done);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
